cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
- Memory-side responder for the 8-bit Von Neumann CPU's single unified bus. The CPU issues instruction fetches and data reads/writes on this bus.
- Accepts one request at a time on a req/ready handshake and inserts a fixed number of wait states.
- Performs the access on an internal synchronous RAM and returns read data to the CPU's datain path.
- Sits between the CPU core and program/data storage. It replaces the ad-hoc memory stimulus that benches drive today.

Parameters:
- ADDR_W, 8, address width; RAM depth = 2**ADDR_W bytes.
- DATA_W, 8, data width.
- WAIT_CYCLES, 1, wait states per access; legal range 0..15.
- IO_ADDR, 8'hFF, address of the memory-mapped output register (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- req  in  1  CPU access request; held high with address/readwrite/wdata stable until ready.
- address  in  ADDR_W  byte address.
- readwrite  in  1  1 = write, 0 = read.
- wdata  in  DATA_W  write data from CPU.
- rdata  out  DATA_W  read data to CPU datain; valid only while ready=1 on a read.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while a transaction is in flight (state != IDLE).
- io_out  out  DATA_W  memory-mapped output register; tied to 0 without the optional feature.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, ready=0, busy=0, rdata=0, io_out=0, wait counter=0. RAM contents are not cleared.
- FSM states are IDLE, WAIT, RESP.
- IDLE: on an edge with req=1, latch address, readwrite and wdata; busy=1. If WAIT_CYCLES=0 go to RESP, else go to WAIT with cnt=WAIT_CYCLES.
- WAIT: decrement cnt each edge. On the edge where cnt==1, go to RESP.
- Entering RESP (the same edge): perform the access.
  - Write: RAM[addr]<=wdata.
  - Read: rdata<=RAM[addr].
- RESP lasts exactly one cycle with ready=1, then returns to IDLE. rdata holds its value until the next read completes.
- Latency: with req sampled at edge E, ready is high in the cycle after edge E+WAIT_CYCLES.
  - WAIT_CYCLES=0: ready follows 1 cycle after sample.
  - WAIT_CYCLES=1: ready follows 2 cycles after sample.
- req is ignored in WAIT and RESP. Changes to address/readwrite/wdata after the IDLE sample have no effect.
- Back-to-back: if req stays high through RESP, the next request is sampled in IDLE at the following edge. Minimum issue interval is WAIT_CYCLES+2 cycles.
- Reset mid-transaction: abort immediately. A write not yet committed (still in WAIT) is never performed. ready stays 0.
- Address wrap: none needed; the full 2**ADDR_W space is backed by RAM.

Optional Feature:
- Macro CPU_MEM_MMIO_OUT_EN.
- Defined:
  - Writes to IO_ADDR update io_out instead of RAM.
  - Reads of IO_ADDR return io_out.
  - Timing is identical to RAM accesses.
- Undefined: IO_ADDR is ordinary RAM and io_out is constant 0.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W and DATA_W defaults.
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - RW_READ=1'b0 and RW_WRITE=1'b1 constants.
- One sub-module, cpu_mem_array: synchronous single-port RAM with we, addr, din and registered dout. The responder FSM drives it.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> ready=0, busy=0, rdata=8'h00, io_out=8'h00.
- WAIT_CYCLES=1: write 8'hA5 to 8'h10, then read 8'h10 -> ready pulses exactly 2 cycles after each req sample; read returns rdata=8'hA5.
- WAIT_CYCLES=0, req held high across 3 reads of 8'h00/8'h01/8'h02 (preloaded 8'h11/8'h22/8'h33) -> ready every 2 cycles; rdata 11, 22, 33 in order.
- Reset mid-write: write 8'h5A to 8'h20 with WAIT_CYCLES=3, drop rst_n during WAIT -> no ready; a later read of 8'h20 returns its prior value 8'h00.
- Input change during WAIT: change address and wdata after the sample -> the access uses the sampled values only.
- CPU_MEM_MMIO_OUT_EN defined: write 8'h3C to 8'hFF -> io_out=8'h3C after ready; read 8'hFF returns 8'h3C; RAM[8'hFF] unchanged. Undefined: io_out stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, responder FSM encoding and bus direction constants
// for the 8-bit CPU memory path.
package cpu_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if: unified CPU memory bus (req/ready handshake) with
// master (CPU) and slave (memory responder) views.
interface cpu_mem_responder_if #(
  parameter int ADDR_W = cpu_pkg::DEF_ADDR_W,
  parameter int DATA_W = cpu_pkg::DEF_DATA_W
);

  logic              req;
  logic [ADDR_W-1:0] address;
  logic              readwrite;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;

  modport master (
    output req, address, readwrite, wdata,
    input  rdata, ready, busy
  );

  modport slave (
    input  req, address, readwrite, wdata,
    output rdata, ready, busy
  );

endinterface

// File: rtl/cpu_mem_array.sv
// cpu_mem_array: single-port synchronous RAM with registered read data.
// Read data reflects the array contents before any same-edge write.
module cpu_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: memory-side responder for the CPU bus with WAIT_CYCLES wait states.
// Define CPU_MEM_MMIO_OUT_EN to map IO_ADDR onto the io_out register instead of RAM.
module cpu_mem_responder
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] IO_ADDR     = {ADDR_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cpu_mem_responder_if.slave       bus,
  output logic [DATA_W-1:0]        io_out
);

`ifdef CPU_MEM_MMIO_OUT_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, acc_addr;
  logic              rw_q, acc_rw;
  logic [DATA_W-1:0] wdata_q, acc_din;
  logic              hit_q, acc_hit;
  logic              commit;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] rdata_q, rdata_c;

  // The access fires on the edge that enters RESP; with zero wait states that
  // is the sampling edge itself, so IDLE steers the live bus into the RAM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;
    acc_addr = addr_q;
    acc_rw   = rw_q;
    acc_din  = wdata_q;
    acc_hit  = hit_q;
    unique case (state_q)
      IDLE: begin
        acc_addr = bus.address;
        acc_rw   = bus.readwrite;
        acc_din  = bus.wdata;
        acc_hit  = MMIO_EN && (bus.address == IO_ADDR);
        if (bus.req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= RW_READ;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.req) begin
        addr_q  <= acc_addr;
        rw_q    <= acc_rw;
        wdata_q <= acc_din;
        hit_q   <= acc_hit;
      end
      if (state_q == RESP && rw_q == RW_READ) begin
        rdata_q <= rdata_c;
      end
    end
  end

  // Gating with rst_n guarantees an aborted write never reaches the array.
  assign ram_we = rst_n && commit && (acc_rw == RW_WRITE) && !acc_hit;

  cpu_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (acc_addr),
    .din  (acc_din),
    .dout (ram_dout)
  );

`ifdef CPU_MEM_MMIO_OUT_EN
  logic [DATA_W-1:0] io_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_q <= '0;
    end else if (commit && acc_rw == RW_WRITE && acc_hit) begin
      io_q <= acc_din;
    end
  end

  assign io_out = io_q;
`else
  assign io_out = '0;
`endif

  assign rdata_c   = hit_q ? io_out : ram_dout;
  assign bus.rdata = (state_q == RESP && rw_q == RW_READ) ? rdata_c : rdata_q;
  assign bus.ready = (state_q == RESP);
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed scoreboard bench driving three responders
// (WAIT_CYCLES 0, 1 and 3) over one shared stimulus bus selected by sel.
module tb_cpu_mem_responder;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [7:0] address;
  logic       readwrite;
  logic [7:0] wdata;
  logic [1:0] sel;
  int         cur_wc;

  always #5 clk = ~clk;

  cpu_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus_w0 ();
  cpu_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus_w1 ();
  cpu_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus_w3 ();

  assign bus_w0.req       = req && (sel == 2'd0);
  assign bus_w0.address   = address;
  assign bus_w0.readwrite = readwrite;
  assign bus_w0.wdata     = wdata;
  assign bus_w1.req       = req && (sel == 2'd1);
  assign bus_w1.address   = address;
  assign bus_w1.readwrite = readwrite;
  assign bus_w1.wdata     = wdata;
  assign bus_w3.req       = req && (sel == 2'd2);
  assign bus_w3.address   = address;
  assign bus_w3.readwrite = readwrite;
  assign bus_w3.wdata     = wdata;

  logic [7:0] io_w0, io_w1, io_w3;

  cpu_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0), .IO_ADDR(8'hFF)) dut_w0 (
    .clk(clk), .rst_n(rst_n), .bus(bus_w0.slave), .io_out(io_w0)
  );
  cpu_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1), .IO_ADDR(8'hFF)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .bus(bus_w1.slave), .io_out(io_w1)
  );
  cpu_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(3), .IO_ADDR(8'hFF)) dut_w3 (
    .clk(clk), .rst_n(rst_n), .bus(bus_w3.slave), .io_out(io_w3)
  );

  logic       ready_m, busy_m;
  logic [7:0] rdata_m, io_m;

  always_comb begin
    ready_m = bus_w0.ready;
    busy_m  = bus_w0.busy;
    rdata_m = bus_w0.rdata;
    io_m    = io_w0;
    case (sel)
      2'd1: begin
        ready_m = bus_w1.ready;
        busy_m  = bus_w1.busy;
        rdata_m = bus_w1.rdata;
        io_m    = io_w1;
      end
      2'd2: begin
        ready_m = bus_w3.ready;
        busy_m  = bus_w3.busy;
        rdata_m = bus_w3.rdata;
        io_m    = io_w3;
      end
      default: ;
    endcase
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       seen;
  int         gap;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic popCheck(input string tag);
    logic [7:0] e;
    checkOutput({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({tag, "_rdata"}, 32'(rdata_m), 32'(e));
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [7:0] addr,
                               input logic [7:0] wd, input logic [7:0] exp_rd);
    @(negedge clk);
    req       = 1'b1;
    readwrite = rw;
    address   = addr;
    wdata     = wd;
    if (rw == RW_READ) exp_q.push_back(exp_rd);
  endtask

  task automatic doAccess(input logic rw, input logic [7:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input bit perturb, input string tag);
    int cyc;
    applyStimulus(rw, addr, wd, exp_rd);
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (perturb && cyc == 1) begin
        address = addr + 8'd1;
        wdata   = 8'h99;
      end
    end while (!ready_m && cyc < 20);
    checkOutput({tag, "_lat"}, 32'(cyc), 32'(cur_wc + 1));
    checkOutput({tag, "_busy"}, 32'(busy_m), 32'd1);
    if (rw == RW_READ) popCheck(tag);
    req = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 32'(ready_m), 32'd0);
  endtask

  initial begin
    req       = 1'b0;
    readwrite = RW_READ;
    address   = 8'h00;
    wdata     = 8'h00;
    sel       = 2'd0;
    cur_wc    = 0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      checkOutput($sformatf("rst%0d_ready", s), 32'(ready_m), 32'd0);
      checkOutput($sformatf("rst%0d_busy", s), 32'(busy_m), 32'd0);
      checkOutput($sformatf("rst%0d_rdata", s), 32'(rdata_m), 32'h00);
      checkOutput($sformatf("rst%0d_io", s), 32'(io_m), 32'h00);
    end

    // One wait state: two-cycle latency, write then read back.
    sel = 2'd1; cur_wc = 1;
    doAccess(RW_WRITE, 8'h10, 8'hA5, 8'h00, 1'b0, "wc1_wr");
    doAccess(RW_READ,  8'h10, 8'h00, 8'hA5, 1'b0, "wc1_rd");

    // Zero wait states: preload, then three reads with req held high.
    sel = 2'd0; cur_wc = 0;
    doAccess(RW_WRITE, 8'h00, 8'h11, 8'h00, 1'b0, "pre0");
    doAccess(RW_WRITE, 8'h01, 8'h22, 8'h00, 1'b0, "pre1");
    doAccess(RW_WRITE, 8'h02, 8'h33, 8'h00, 1'b0, "pre2");
    @(negedge clk);
    req = 1'b1; readwrite = RW_READ; address = 8'h00;
    exp_q.push_back(8'h11);
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!ready_m && gap < 20);
      checkOutput($sformatf("b2b%0d_gap", k), 32'(gap), (k == 0) ? 32'd1 : 32'd2);
      popCheck($sformatf("b2b%0d", k));
      if (k < 2) begin
        address = 8'(k + 1);
        exp_q.push_back(8'(8'h11 * (k + 2)));
      end
    end
    req = 1'b0;
    @(negedge clk);
    checkOutput("b2b_pulse", 32'(ready_m), 32'd0);

    // Three wait states: reset during WAIT must drop the pending write.
    sel = 2'd2; cur_wc = 3;
    doAccess(RW_WRITE, 8'h20, 8'h00, 8'h00, 1'b0, "pre20");
    applyStimulus(RW_WRITE, 8'h20, 8'h5A, 8'h00);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy_m), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy_clr", 32'(busy_m), 32'd0);
    rst_n = 1'b1;
    req   = 1'b0;
    seen  = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready_m) seen = 1'b1;
    end
    checkOutput("abort_noready", 32'(seen), 32'd0);
    doAccess(RW_READ, 8'h20, 8'h00, 8'h00, 1'b0, "abort_rd");

    // Address/wdata changed after the sample must not affect the access.
    doAccess(RW_WRITE, 8'h31, 8'h00, 8'h00, 1'b0, "pre31");
    doAccess(RW_WRITE, 8'h30, 8'h77, 8'h00, 1'b1, "chg_wr");
    doAccess(RW_READ,  8'h30, 8'h00, 8'h77, 1'b0, "chg_rd30");
    doAccess(RW_READ,  8'h31, 8'h00, 8'h00, 1'b0, "chg_rd31");

    // IO_ADDR access: io_out register when mapped, plain RAM otherwise.
    sel = 2'd1; cur_wc = 1;
    doAccess(RW_WRITE, 8'hFF, 8'h3C, 8'h00, 1'b0, "io_wr");
`ifdef CPU_MEM_MMIO_OUT_EN
    checkOutput("io_out", 32'(io_m), 32'h3C);
`else
    checkOutput("io_out", 32'(io_m), 32'h00);
`endif
    doAccess(RW_READ, 8'hFF, 8'h00, 8'h3C, 1'b0, "io_rd");

    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
